// File: rtl/dotprod_result_reader_if.sv
// -----------------------------------------------------------------------------
// dotprod_result_reader_if
//   Result stream between the dot-product result reader and its consumer.
//   Each beat carries one result word and the memory address it came from.
//   The word moves on a clock edge where res_valid and res_ready are both high.
//
//   Signals
//     res_valid  master->slave  a result is presented
//     res_ready  slave->master  consumer accepts the presented result
//     res_data   master->slave  result value, 2*DATA_WIDTH+1 bits
//     res_addr   master->slave  source address, ADDRESS_WIDTH bits
//
//   Modports
//     master  driven by dotprod_result_reader
//     slave   used by the result consumer
// -----------------------------------------------------------------------------
interface dotprod_result_reader_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 12
);
    logic                     res_valid;
    logic                     res_ready;
    logic [2*DATA_WIDTH:0]    res_data;
    logic [ADDRESS_WIDTH-1:0] res_addr;

    modport master (output res_valid, output res_data, output res_addr, input res_ready);
    modport slave  (input res_valid, input res_data, input res_addr, output res_ready);
endinterface

// File: rtl/dotprod_result_reader.sv
// -----------------------------------------------------------------------------
// dotprod_result_reader
//   Read-side master for the dot-product result memory. A rising edge of start
//   launches a sweep of rdaddr over 0..2**ADDRESS_WIDTH-1. Each read returns
//   final_output RD_LATENCY edges after the RD sample edge; the word is stored
//   with its address in a FIFO_DEPTH-entry buffer and drained over a
//   valid/ready stream. Reads are only issued while the buffer is guaranteed to
//   have room for every read already in flight, so no capture is ever dropped.
//
//   Ports
//     clk           clock, rising edge
//     rst           asynchronous active-high reset
//     start         sweep request (rising edge detected internally)
//     RD            read strobe to the result memory
//     rdaddr        read address
//     final_output  read data from the result memory
//     res           result stream (dotprod_result_reader_if.master)
//     busy          high while reading or draining
//     done          one-cycle pulse once the sweep has fully drained
//     res_sum       sum of all results streamed in the current sweep
//
//   Configuration
//     RESULT_SUM_EN  when defined, res_sum accumulates every popped result and
//                    clears on rst and on each accepted start edge; when
//                    undefined, res_sum is tied to 0.
//
//   Constraints: RD_LATENCY >= 1; FIFO_DEPTH a power of 2, >= RD_LATENCY+1.
// -----------------------------------------------------------------------------
module dotprod_result_reader #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 12,
    parameter int RD_LATENCY    = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                RD,
    output logic [ADDRESS_WIDTH-1:0]            rdaddr,
    input  logic [2*DATA_WIDTH:0]               final_output,
    dotprod_result_reader_if.master             res,
    output logic                                busy,
    output logic                                done,
    output logic [2*DATA_WIDTH+ADDRESS_WIDTH:0] res_sum
);
    localparam int RES_W = 2*DATA_WIDTH + 1;
    localparam int SUM_W = RES_W + ADDRESS_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = (ADDRESS_WIDTH+1)'((1 << ADDRESS_WIDTH) - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                   state, state_next;
    logic                     start_q;
    logic                     start_rise;
    // One bit wider than rdaddr so the counter can sit past the last address
    // without wrapping back onto address 0.
    logic [ADDRESS_WIDTH:0]   addr_cnt;

    // Tag pipeline: tracks which issued reads are still waiting for data.
    logic                     tag_vld  [RD_LATENCY];
    logic [ADDRESS_WIDTH-1:0] tag_addr [RD_LATENCY];

    logic [RES_W-1:0]         data_mem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         count, inflight, free_slots;
    logic                     push, pop;

    assign start_rise = start & ~start_q;
    assign rdaddr     = addr_cnt[ADDRESS_WIDTH-1:0];
    assign push       = tag_vld[RD_LATENCY-1];
    assign pop        = res.res_valid & res.res_ready;
    assign free_slots = CNT_W'(FIFO_DEPTH) - count;

    assign res.res_valid = (count != '0);
    assign res.res_data  = data_mem[rd_ptr];
    assign res.res_addr  = addr_mem[rd_ptr];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_vld[i]);
        end
    end

    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        RD         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) state_next = S_READ;
            end
            S_READ: begin
                busy = 1'b1;
                // Issue only when every in-flight read plus this one has a slot.
                RD = (free_slots > inflight);
                if (RD && (addr_cnt == LAST_ADDR)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((inflight == '0) && (count == '0)) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            addr_cnt <= '0;
        end else begin
            state   <= state_next;
            start_q <= start;
            if (state_next == S_DONE) begin
                addr_cnt <= '0;
            end else if (RD) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_vld[i]  <= 1'b0;
                tag_addr[i] <= '0;
            end
        end else begin
            tag_vld[0]  <= RD;
            tag_addr[0] <= rdaddr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_addr[i] <= tag_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; an entry is only ever read after it
    // was written, and occupancy is tracked by the reset count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= final_output;
            addr_mem[wr_ptr] <= tag_addr[RD_LATENCY-1];
        end
    end

`ifdef RESULT_SUM_EN
    logic [SUM_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if ((state == S_IDLE) && start_rise) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + SUM_W'(res.res_data);
        end
    end

    assign res_sum = sum_q;
`else
    assign res_sum = '0;
`endif

endmodule

// File: tb/tb_dotprod_result_reader.sv
// -----------------------------------------------------------------------------
// tb_dotprod_result_reader
//   Two readers share clk, rst, start and res_ready: one with RD_LATENCY=1 and
//   one with RD_LATENCY=3. Each has its own result memory returning 3*addr+1.
//   A sweep-level model (issued/popped counts, issue times, running sum)
//   predicts every cycle what each reader must present.
// -----------------------------------------------------------------------------
module tb_dotprod_result_reader;
    localparam int AW    = 4;
    localparam int DW    = 12;
    localparam int RW    = 2*DW + 1;
    localparam int SW    = RW + AW;
    localparam int DEPTH = 4;
    localparam int N     = 16;
`ifdef RESULT_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif
    localparam longint SWEEP_SUM = SUM_EN ? 376 : 0;

    logic clk;
    logic rst;
    logic start;
    logic res_ready;

    logic          rd_a, rd_b;
    logic [AW-1:0] rdaddr_a, rdaddr_b;
    logic [RW-1:0] fo_a, fo_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [SW-1:0] sum_a, sum_b;

    dotprod_result_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
    dotprod_result_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

    assign if_a.res_ready = res_ready;
    assign if_b.res_ready = res_ready;

    dotprod_result_reader #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .RD(rd_a), .rdaddr(rdaddr_a),
        .final_output(fo_a), .res(if_a), .busy(busy_a), .done(done_a), .res_sum(sum_a)
    );

    dotprod_result_reader #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .FIFO_DEPTH(DEPTH)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .RD(rd_b), .rdaddr(rdaddr_b),
        .final_output(fo_b), .res(if_b), .busy(busy_b), .done(done_b), .res_sum(sum_b)
    );

    // Result memories: data for address a is 3*a+1, RD_LATENCY edges after RD.
    logic [RW-1:0] mem_b0, mem_b1, mem_b2;

    always @(posedge clk) begin
        if (rd_a) fo_a <= {{(RW-AW){1'b0}}, rdaddr_a} * RW'(3) + RW'(1);
        mem_b0 <= rd_b ? ({{(RW-AW){1'b0}}, rdaddr_b} * RW'(3) + RW'(1)) : '0;
        mem_b1 <= mem_b0;
        mem_b2 <= mem_b1;
    end
    assign fo_b = mem_b2;

    // Per-instance views for the compare process.
    logic          o_rd     [2];
    logic [AW-1:0] o_rdaddr [2];
    logic          o_valid  [2];
    logic [RW-1:0] o_data   [2];
    logic [AW-1:0] o_addr   [2];
    logic          o_busy   [2];
    logic          o_done   [2];
    logic [SW-1:0] o_sum    [2];

    assign o_rd[0] = rd_a;          assign o_rd[1] = rd_b;
    assign o_rdaddr[0] = rdaddr_a;  assign o_rdaddr[1] = rdaddr_b;
    assign o_valid[0] = if_a.res_valid;  assign o_valid[1] = if_b.res_valid;
    assign o_data[0] = if_a.res_data;    assign o_data[1] = if_b.res_data;
    assign o_addr[0] = if_a.res_addr;    assign o_addr[1] = if_b.res_addr;
    assign o_busy[0] = busy_a;      assign o_busy[1] = busy_b;
    assign o_done[0] = done_a;      assign o_done[1] = done_b;
    assign o_sum[0] = sum_a;        assign o_sum[1] = sum_b;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sweep model state.
    int     lat       [2] = '{1, 3};
    bit     active    [2];
    int     issued    [2];
    int     popped    [2];
    int     since     [2];
    longint msum      [2];
    int     issue_cyc [2][N];
    int     done_seen [2];
    int     cyc        = 0;
    bit     start_prev = 1'b0;
    bit     gap_mon    = 1'b0;
    int     gaps       = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare process: observe at the falling edge, then advance the model
    // to what the coming rising edge will do.
    always @(negedge clk) begin
        bit     idle_before [2];
        bit     exp_busy, exp_done;
        int     avail;
        longint exp_sum;
        cyc++;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst_busy%0d", k), 64'(o_busy[k]), 64'(0));
                check($sformatf("rst_valid%0d", k), 64'(o_valid[k]), 64'(0));
                check($sformatf("rst_rd%0d", k), 64'(o_rd[k]), 64'(0));
                check($sformatf("rst_sum%0d", k), 64'(o_sum[k]), 64'(0));
                active[k] = 1'b0;
                issued[k] = 0;
                popped[k] = 0;
                since[k]  = 0;
                msum[k]   = 0;
            end
            start_prev = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                avail = 0;
                for (int i = 0; i < issued[k]; i++) begin
                    if (issue_cyc[k][i] + lat[k] + 1 <= cyc) avail++;
                end
                exp_done = active[k] && (popped[k] == N) && (since[k] == 1);
                exp_busy = active[k] && !((popped[k] == N) && (since[k] >= 1));
                exp_sum  = SUM_EN ? msum[k] : 0;

                check($sformatf("valid%0d", k), 64'(o_valid[k]), 64'(avail > popped[k]));
                if (o_valid[k]) begin
                    check($sformatf("res_addr%0d", k), 64'(o_addr[k]), 64'(popped[k] % N));
                    check($sformatf("res_data%0d", k), 64'(o_data[k]), 64'(3*popped[k] + 1));
                end
                check($sformatf("busy%0d", k), 64'(o_busy[k]), 64'(exp_busy));
                check($sformatf("done%0d", k), 64'(o_done[k]), 64'(exp_done));
                check($sformatf("res_sum%0d", k), 64'(o_sum[k]), 64'(exp_sum));
                check($sformatf("occupancy%0d", k), 64'((issued[k] - popped[k]) <= DEPTH), 64'(1));
                if (o_rd[k]) begin
                    check($sformatf("rd_legal%0d", k), 64'(active[k] && issued[k] < N), 64'(1));
                    check($sformatf("rdaddr%0d", k), 64'(o_rdaddr[k]), 64'(issued[k] % N));
                end else if (active[k] && issued[k] < N) begin
                    check($sformatf("rdaddr_hold%0d", k), 64'(o_rdaddr[k]), 64'(issued[k]));
                end

                if (o_done[k]) done_seen[k]++;
                if (k == 0 && gap_mon && active[k] && popped[k] < N && !o_valid[k]) gaps++;

                idle_before[k] = !active[k];
                if (o_rd[k] && issued[k] < N) begin
                    issue_cyc[k][issued[k]] = cyc;
                    issued[k]++;
                end
                if (active[k] && (avail > popped[k]) && res_ready) begin
                    msum[k] += 3*popped[k] + 1;
                    popped[k]++;
                    since[k] = 0;
                end else if (active[k] && popped[k] == N) begin
                    since[k]++;
                end
                if (exp_done) active[k] = 1'b0;
            end
            if (start && !start_prev) begin
                for (int k = 0; k < 2; k++) begin
                    if (idle_before[k]) begin
                        active[k] = 1'b1;
                        issued[k] = 0;
                        popped[k] = 0;
                        since[k]  = 0;
                        msum[k]   = 0;
                    end
                end
            end
            start_prev = start;
        end
    end

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit toggle);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 400 && !idle; c++) begin
            @(posedge clk) #1;
            if (toggle) res_ready = ~res_ready;
            idle = !active[0] && !active[1];
        end
        check({name, "_complete"}, 64'(idle), 64'(1));
    endtask

    task automatic wait_issued(input string name, input int n);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk) #1;
            hit = (issued[0] >= n);
        end
        check({name, "_reached"}, 64'(hit), 64'(1));
    endtask

    initial begin
        int d0, d1;
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdaddr_a", 64'(rdaddr_a), 64'(0));
        check("reset_done_a", 64'(done_a), 64'(0));
        check("reset_busy_b", 64'(busy_b), 64'(0));
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: full-rate sweep; start held high through the end must not retrigger.
        d0 = done_seen[0]; d1 = done_seen[1];
        @(posedge clk) #1 start = 1'b1;
        wait_idle("t1_sweep", 1'b0);
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        check("t1_popped_a", 64'(popped[0]), 64'(16));
        check("t1_popped_b", 64'(popped[1]), 64'(16));
        check("t1_done_once_a", 64'(done_seen[0] - d0), 64'(1));
        check("t1_done_once_b", 64'(done_seen[1] - d1), 64'(1));
        check("t1_sum_a", 64'(sum_a), 64'(SWEEP_SUM));
        check("t1_sum_b", 64'(sum_b), 64'(SWEEP_SUM));
        check("t1_busy_after", 64'(busy_a), 64'(0));

        // 2: consumer stalled; reads stop once the buffer is committed.
        res_ready = 1'b0;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check("t2_issued_a", 64'(issued[0]), 64'(4));
        check("t2_rd_a", 64'(rd_a), 64'(0));
        check("t2_rdaddr_a", 64'(rdaddr_a), 64'(4));
        check("t2_rdaddr_b", 64'(rdaddr_b), 64'(4));
        check("t2_valid_a", 64'(if_a.res_valid), 64'(1));
        check("t2_head_addr_a", 64'(if_a.res_addr), 64'(0));
        check("t2_head_data_a", 64'(if_a.res_data), 64'(1));
        gaps      = 0;
        gap_mon   = 1'b1;
        res_ready = 1'b1;
        wait_idle("t2_sweep", 1'b0);
        gap_mon = 1'b0;
        check("t2_no_gap_a", 64'(gaps), 64'(0));
        check("t2_popped_a", 64'(popped[0]), 64'(16));

        // 3: ready toggling every cycle.
        pulse_start();
        wait_idle("t3_sweep", 1'b1);
        res_ready = 1'b1;
        check("t3_popped_b", 64'(popped[1]), 64'(16));

        // 4: extra start mid-sweep is ignored; a later start sweeps again.
        d0 = done_seen[0]; d1 = done_seen[1];
        pulse_start();
        wait_issued("t4_addr7", 7);
        pulse_start();
        wait_idle("t4_sweep", 1'b0);
        check("t4_done_once_a", 64'(done_seen[0] - d0), 64'(1));
        check("t4_done_once_b", 64'(done_seen[1] - d1), 64'(1));
        pulse_start();
        wait_idle("t4_second", 1'b0);
        check("t4_sum_a", 64'(sum_a), 64'(SWEEP_SUM));
        check("t4_popped_a", 64'(popped[0]), 64'(16));

        // 5: asynchronous reset mid-sweep.
        pulse_start();
        wait_issued("t5_addr9", 9);
        @(posedge clk) #3 rst = 1'b1;
        #1;
        check("t5_rst_valid_a", 64'(if_a.res_valid), 64'(0));
        check("t5_rst_valid_b", 64'(if_b.res_valid), 64'(0));
        check("t5_rst_busy_a", 64'(busy_a), 64'(0));
        check("t5_rst_rdaddr_a", 64'(rdaddr_a), 64'(0));
        check("t5_rst_rd_b", 64'(rd_b), 64'(0));
        check("t5_rst_sum_a", 64'(sum_a), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_seen[0]; d1 = done_seen[1];
        pulse_start();
        wait_idle("t5_sweep", 1'b0);
        check("t5_popped_a", 64'(popped[0]), 64'(16));
        check("t5_popped_b", 64'(popped[1]), 64'(16));
        check("t5_done_once_a", 64'(done_seen[0] - d0), 64'(1));
        check("t5_sum_b", 64'(sum_b), 64'(SWEEP_SUM));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
